// File: rtl/lin_pkg.sv
// Shared helpers for the 2-D tile datapath (feature_tile_assembler -> delay_buffer_2d).
//
// Tile indexing convention used by every block in this chain:
//   tile[feature][sample] -- the feature index is the outer (row) dimension and the
//   sample index is the inner (column) dimension, so tile[f][n] is feature f of the
//   n-th sample placed into the tile. Tile dimensions are module parameters; this
//   package only provides the width helpers derived from them.
package lin_pkg;

    // Width of a counter that must hold values 0..n inclusive.
    function automatic int cnt_w(input int n);
        return $clog2(n + 1);
    endfunction

    // Width of an index that addresses 0..n-1; never narrower than one bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/feature_tile_assembler_bank.sv
// tile_bank: storage for one [NUM_FEATURES][N] tile plus the number of valid columns.
//
// Ports:
//   clk, rst_n   clock and asynchronous active-low reset (clears storage and count)
//   wr_en        write the incoming feature vector into column `col`
//   col          column index of the write
//   close        this write ends the tile: zero columns above `col`, latch count
//   in_data      one sample's feature vector, in_data[f]
//   data         stored tile, data[f][n]
//   cols         number of valid columns of the last closed tile
module tile_bank
    import lin_pkg::*;
#(
    parameter int NUM_FEATURES = 4,
    parameter int N            = 4,
    parameter int PRECISION    = 4
) (
    input  logic                                          clk,
    input  logic                                          rst_n,
    input  logic                                          wr_en,
    input  logic [idx_w(N)-1:0]                           col,
    input  logic                                          close,
    input  logic [NUM_FEATURES-1:0][PRECISION-1:0]        in_data,
    output logic [NUM_FEATURES-1:0][N-1:0][PRECISION-1:0] data,
    output logic [cnt_w(N)-1:0]                           cols
);

    localparam int KW = cnt_w(N);

    // NOTE: this storage is reset on purpose: the tile output must read as all
    // zeros straight after reset, so it is built from resettable flops, not a RAM.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data <= '0;
            cols <= '0;
        end else if (wr_en) begin
            for (int f = 0; f < NUM_FEATURES; f++) begin
                for (int n = 0; n < N; n++) begin
                    if (n == int'(col)) begin
                        data[f][n] <= in_data[f];
                    end else if (close && (n > int'(col))) begin
                        // Tail columns of a short tile must not leak an older tile.
                        data[f][n] <= '0;
                    end
                end
            end
            if (close) begin
                cols <= KW'(col) + KW'(1);
            end
        end
    end

endmodule

// File: rtl/feature_tile_assembler.sv
// feature_tile_assembler: packs a stream of feature vectors into 2-D tiles
// [NUM_FEATURES][N] for delay_buffer_2d, using two ping-pong tile banks so one
// tile fills while the other is held on the output.
//
// Ports:
//   clk, rst_n   clock and asynchronous active-low reset
//   in_valid     input beat valid
//   in_ready     a beat can be accepted (depends only on registered occupancy)
//   in_data      one sample's feature vector, in_data[f]
//   in_last      closes the current tile after this beat (zero-fills the rest)
//   out_valid    a closed tile is presented
//   out_ready    downstream takes the tile
//   odata        presented tile, odata[f][n] = feature f of the n-th beat
//   out_cols     valid columns in the presented tile (1..N)
module feature_tile_assembler
    import lin_pkg::*;
#(
    parameter int NUM_FEATURES = 4,
    parameter int N            = 4,
    parameter int PRECISION    = 4
) (
    input  logic                                          clk,
    input  logic                                          rst_n,
    input  logic                                          in_valid,
    output logic                                          in_ready,
    input  logic [NUM_FEATURES-1:0][PRECISION-1:0]        in_data,
    input  logic                                          in_last,
    output logic                                          out_valid,
    input  logic                                          out_ready,
    output logic [NUM_FEATURES-1:0][N-1:0][PRECISION-1:0] odata,
    output logic [cnt_w(N)-1:0]                           out_cols
);

    localparam int CW = idx_w(N);
    localparam int KW = cnt_w(N);

    logic [CW-1:0] col;        // next column to write in the filling bank
    logic          wr_sel;     // bank being filled
    logic          rd_sel;     // bank presented on the output
    logic [1:0]    occupancy;  // closed tiles waiting for downstream (0..2)

    logic accept;
    logic close;
    logic consume;

    logic [1:0][NUM_FEATURES-1:0][N-1:0][PRECISION-1:0] bank_data;
    logic [1:0][KW-1:0]                                 bank_cols;

    // Both flags come from the occupancy register alone, so out_ready never
    // reaches in_ready combinationally and in_data never reaches odata.
    assign in_ready  = (occupancy < 2'd2);
    assign out_valid = (occupancy != 2'd0);

    assign accept  = in_valid && in_ready;
    assign close   = accept && (in_last || (col == CW'(N - 1)));
    assign consume = out_valid && out_ready;

    for (genvar b = 0; b < 2; b++) begin : g_bank
        tile_bank #(
            .NUM_FEATURES(NUM_FEATURES),
            .N           (N),
            .PRECISION   (PRECISION)
        ) u_bank (
            .clk    (clk),
            .rst_n  (rst_n),
            .wr_en  (accept && (wr_sel == 1'(b))),
            .col    (col),
            .close  (close),
            .in_data(in_data),
            .data   (bank_data[b]),
            .cols   (bank_cols[b])
        );
    end

    assign odata    = bank_data[rd_sel];
    assign out_cols = bank_cols[rd_sel];

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col       <= '0;
            wr_sel    <= 1'b0;
            rd_sel    <= 1'b0;
            occupancy <= 2'd0;
        end else begin
            if (accept) begin
                col <= close ? '0 : col + CW'(1);
            end
            if (close) begin
                wr_sel <= ~wr_sel;
            end
            if (consume) begin
                rd_sel <= ~rd_sel;
            end
            // A close and a consume on the same edge cancel out.
            case ({close, consume})
                2'b10:   occupancy <= occupancy + 2'd1;
                2'b01:   occupancy <= occupancy - 2'd1;
                default: occupancy <= occupancy;
            endcase
        end
    end

endmodule

// File: tb/tb_feature_tile_assembler.sv
// Self-checking bench for feature_tile_assembler (NUM_FEATURES=4, N=4, PRECISION=4).
// Stimulus pushes hand-computed expected tiles into a scoreboard queue; a monitor
// pops and compares on every output transfer.
module tb_feature_tile_assembler;

    typedef logic [3:0][3:0]       vec_t;   // [index][bits]
    typedef logic [3:0][3:0][3:0]  tile_t;  // [feature][sample][bits]

    typedef struct {
        tile_t      data;
        logic [2:0] cols;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    vec_t       in_data;
    logic       in_last;
    logic       out_valid;
    logic       out_ready;
    tile_t      odata;
    logic [2:0] out_cols;

    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    exp_t exp_q[$];
    int   xfer_cyc[$];
    exp_t mon_e;
    logic stream_on = 1'b0;
    logic ir_drop   = 1'b0;
    int   valid_cnt = 0;

    feature_tile_assembler #(
        .NUM_FEATURES(4),
        .N           (4),
        .PRECISION   (4)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .in_last  (in_last),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .odata    (odata),
        .out_cols (out_cols)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic vec_t v4(input int a0, input int a1, input int a2, input int a3);
        vec_t v;
        v[0] = a0[3:0];
        v[1] = a1[3:0];
        v[2] = a2[3:0];
        v[3] = a3[3:0];
        return v;
    endfunction

    // Rows are given per feature, each listing samples n=0..3.
    function automatic tile_t t4(input vec_t r0, input vec_t r1, input vec_t r2, input vec_t r3);
        tile_t t;
        t[0] = r0;
        t[1] = r1;
        t[2] = r2;
        t[3] = r3;
        return t;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
        checks++;
        if (act !== want) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, want);
        end
    endtask

    task automatic push(input tile_t d, input int c);
        exp_t e;
        e.data = d;
        e.cols = c[2:0];
        exp_q.push_back(e);
    endtask

    task automatic send_beat(input vec_t d, input logic last);
        int waited;
        waited   = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        @(negedge clk);
        while (!in_ready && waited < 20) begin
            waited++;
            @(negedge clk);
        end
        if (!in_ready) begin
            checks++;
            failures++;
            $display("FAIL send_beat_timeout: in_ready=0 after %0d cycles, expected 1", waited);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int w;
        w = 0;
        while (exp_q.size() != 0 && w < 30) begin
            @(posedge clk);
            w++;
        end
        #1;
        check(name, 64'(exp_q.size()), 64'd0);
    endtask

    // Scoreboard monitor: every output transfer must match the oldest expected tile.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_tile: got %h cols %0d, expected no tile", odata, out_cols);
            end else begin
                mon_e = exp_q.pop_front();
                check("tile_data", odata, mon_e.data);
                check("tile_cols", 64'(out_cols), 64'(mon_e.cols));
                xfer_cyc.push_back(cyc);
            end
        end
        if (stream_on) begin
            if (!in_ready) ir_drop <= 1'b1;
            if (out_valid) valid_cnt <= valid_cnt + 1;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_odata", odata, 64'd0);
        check("rst_out_cols", 64'(out_cols), 64'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Full tile, one-cycle latency
        out_ready = 1'b1;
        push(t4(v4(1, 2, 3, 4), v4(5, 6, 7, 8), v4(9, 10, 11, 12), v4(13, 14, 15, 0)), 4);
        send_beat(v4(1, 5, 9, 13), 1'b0);
        send_beat(v4(2, 6, 10, 14), 1'b0);
        send_beat(v4(3, 7, 11, 15), 1'b0);
        send_beat(v4(4, 8, 12, 0), 1'b0);
        @(negedge clk);
        check("full_latency_valid", 64'(out_valid), 64'd1);
        @(posedge clk);
        #1;

        // Backpressure: 8 beats fill both banks, the 9th stalls
        out_ready = 1'b0;
        push(t4(v4(1, 2, 3, 4), v4(1, 2, 3, 4), v4(1, 2, 3, 4), v4(1, 2, 3, 4)), 4);
        push(t4(v4(5, 5, 5, 5), v4(6, 6, 6, 6), v4(7, 7, 7, 7), v4(8, 8, 8, 8)), 4);
        push(t4(v4(9, 1, 15, 0), v4(10, 2, 14, 1), v4(11, 3, 13, 0), v4(12, 4, 12, 1)), 4);
        for (int i = 1; i <= 4; i++) send_beat(v4(i, i, i, i), 1'b0);
        for (int i = 0; i < 4; i++) send_beat(v4(5, 6, 7, 8), 1'b0);
        @(negedge clk);
        check("bp_in_ready_low", 64'(in_ready), 64'd0);
        check("bp_out_valid", 64'(out_valid), 64'd1);
        in_valid = 1'b1;
        in_data  = v4(9, 10, 11, 12);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp_hold_data", odata,
                  t4(v4(1, 2, 3, 4), v4(1, 2, 3, 4), v4(1, 2, 3, 4), v4(1, 2, 3, 4)));
            check("bp_hold_cols", 64'(out_cols), 64'd4);
            check("bp_stall_ready", 64'(in_ready), 64'd0);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(negedge clk);
        check("bp_in_ready_back", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        send_beat(v4(1, 2, 3, 4), 1'b0);
        send_beat(v4(15, 14, 13, 12), 1'b0);
        send_beat(v4(0, 1, 0, 1), 1'b0);
        out_ready = 1'b1;

        // in_last without in_valid is ignored, then a 2-beat partial tile
        in_last = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        in_last = 1'b0;
        push(t4(v4(7, 3, 0, 0), v4(7, 3, 0, 0), v4(7, 3, 0, 0), v4(7, 3, 0, 0)), 2);
        send_beat(v4(7, 7, 7, 7), 1'b0);
        send_beat(v4(3, 3, 3, 3), 1'b1);
        wait_drain("partial_drain");

        // Streaming: 12 back-to-back beats, three tiles 4 cycles apart
        xfer_cyc.delete();
        valid_cnt = 0;
        ir_drop   = 1'b0;
        stream_on = 1'b1;
        push(t4(v4(0, 1, 2, 3), v4(1, 2, 3, 4), v4(2, 3, 4, 5), v4(3, 4, 5, 6)), 4);
        push(t4(v4(4, 5, 6, 7), v4(5, 6, 7, 8), v4(6, 7, 8, 9), v4(7, 8, 9, 10)), 4);
        push(t4(v4(8, 9, 10, 11), v4(9, 10, 11, 12), v4(10, 11, 12, 13), v4(11, 12, 13, 14)), 4);
        for (int k = 0; k < 12; k++) send_beat(v4(k, k + 1, k + 2, k + 3), 1'b0);
        wait_drain("stream_drain");
        stream_on = 1'b0;
        check("stream_in_ready_drop", 64'(ir_drop), 64'd0);
        check("stream_valid_cycles", 64'(valid_cnt), 64'd3);
        check("stream_tile_count", 64'(xfer_cyc.size()), 64'd3);
        if (xfer_cyc.size() == 3) begin
            check("stream_spacing_1", 64'(xfer_cyc[1] - xfer_cyc[0]), 64'd4);
            check("stream_spacing_2", 64'(xfer_cyc[2] - xfer_cyc[1]), 64'd4);
        end

        // Simultaneous close and consume with one tile held
        out_ready = 1'b0;
        push(t4(v4(2, 2, 2, 2), v4(4, 4, 4, 4), v4(6, 6, 6, 6), v4(8, 8, 8, 8)), 4);
        push(t4(v4(15, 0, 15, 0), v4(15, 0, 15, 0), v4(15, 0, 15, 0), v4(15, 0, 15, 0)), 4);
        for (int i = 0; i < 4; i++) send_beat(v4(2, 4, 6, 8), 1'b0);
        send_beat(v4(15, 15, 15, 15), 1'b0);
        send_beat(v4(0, 0, 0, 0), 1'b0);
        send_beat(v4(15, 15, 15, 15), 1'b0);
        out_ready = 1'b1;
        send_beat(v4(0, 0, 0, 0), 1'b1);
        @(negedge clk);
        check("sim_valid_kept", 64'(out_valid), 64'd1);
        @(negedge clk);
        check("sim_no_extra", 64'(out_valid), 64'd0);
        wait_drain("sim_drain");

        // Async reset mid-tile with a tile held
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) send_beat(v4(1, 1, 1, 1), 1'b0);
        send_beat(v4(6, 6, 6, 6), 1'b0);
        send_beat(v4(9, 9, 9, 9), 1'b0);
        check("pre_rst_valid", 64'(out_valid), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_out_valid", 64'(out_valid), 64'd0);
        check("arst_in_ready", 64'(in_ready), 64'd1);
        check("arst_odata", odata, 64'd0);
        check("arst_out_cols", 64'(out_cols), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        push(t4(v4(3, 5, 5, 9), v4(1, 9, 3, 7), v4(4, 2, 5, 9), v4(1, 6, 8, 3)), 4);
        send_beat(v4(3, 1, 4, 1), 1'b0);
        send_beat(v4(5, 9, 2, 6), 1'b0);
        send_beat(v4(5, 3, 5, 8), 1'b0);
        send_beat(v4(9, 7, 9, 3), 1'b0);
        wait_drain("post_rst_drain");

        repeat (3) @(posedge clk);
        check("final_queue_empty", 64'(exp_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
